vector_mac_acc_ctrl: RTL and testbench
======================================

# vector_mac_acc_ctrl

Sequencing and accumulation controller that sits directly upstream of `vector_MAC_int` and consumes its `c_ab` output. It accepts a stream of LEN operand vector pairs (a, b) over a valid/ready handshake and drives the MAC's `a_n_1`/`b_n_1`/`c_n_1` inputs. It feeds `c_ab` back into `c_n_1` so the MAC performs a per-lane dot product seeded with a bias vector. It then holds the finished accumulator vector on a valid/ready output port until a consumer accepts it.

## Interface
- `REG_WIDTH`, 16, lane width; must match the attached MAC.
- `VECTOR`, 8, number of lanes; must match the attached MAC.
- `LEN_WIDTH`, 8, width of the operand-count field.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a job; sampled only in IDLE.
- `len`  in  LEN_WIDTH  number of operand pairs; latched on start.
- `bias_in`  in  REG_WIDTH x VECTOR  accumulator seed; latched on start.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller accepts an operand pair.
- `a_in`, `b_in`  in  REG_WIDTH x VECTOR  operand vectors.
- `mac_a`, `mac_b`, `mac_c`  out  REG_WIDTH x VECTOR  to MAC `a_n_1`/`b_n_1`/`c_n_1`.
- `mac_c_ab`  in  REG_WIDTH x VECTOR  from MAC `c_ab`; the MAC's output register has 1 cycle of latency.
- `out_valid`  out  1  result vector valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  REG_WIDTH x VECTOR  final accumulator.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, `start`=1, `len`≠0: latch `len` and `bias_in`, clear issue counter, set `first`=1, go to RUN.
- IDLE, `start`=1, `len`=0: `out_data` <= `bias_in`, go to DONE.
- RUN:
  - `in_ready` = (count < len_q).
  - Issue = `in_valid` & `in_ready`.
  - On issue: `mac_a`=`a_in`, `mac_b`=`b_in`, count++, `first` clears.
  - Without issue: `mac_a`=`mac_b`=0, so the accumulator holds its value across bubbles.
  - `mac_c` = `first` ? bias_q : `mac_c_ab`.
  - The issue that makes count == len_q moves the FSM to DRAIN.
- DRAIN: a single cycle. `mac_a`=`mac_b`=0, `mac_c`=`mac_c_ab`, `out_data` <= `mac_c_ab`, go to DONE.
- DONE:
  - `out_valid`=1; `out_data` stays stable.
  - On `out_valid`&`out_ready`: go to IDLE.
  - `start` is ignored in DONE, including in the handshake cycle.
- IDLE/DONE: `mac_a`=`mac_b`=`mac_c`=0.
- Arithmetic is the MAC's. Per lane, `out_data` = (bias + Σ aᵢ·bᵢ) mod 2^REG_WIDTH, unsigned, truncated.
- `start` outside IDLE is ignored. `in_ready`=0 outside RUN.
- Reset in any state:
  - FSM goes to IDLE; count, `first`, `out_data`, bias_q and len_q are cleared.
  - The partial accumulation is discarded.
  - The MAC register is not reset; the controller never consumes `mac_c_ab` before re-seeding from bias.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `out_data`=0, `mac_a`/`mac_b`/`mac_c`=0.
- `start` in cycle t makes RUN active in t+1; `in_ready` can rise in t+1.
- Throughput: one operand pair per cycle; `in_valid` bubbles are allowed anywhere.
- Latency: with the last issue in cycle t, DRAIN is cycle t+1 and `out_valid`=1 from cycle t+2.
- Zero-bubble job of length L: `start` at t0, `out_valid` at t0+L+2.
- `len`=0: `start` at t0, `out_valid` at t0+1, `out_data`=bias.
- Earliest restart: the handshake in cycle t returns to IDLE in t+1; `start` accepted in t+1.
- `mac_*` outputs and `in_ready` are combinational from state, `first`, count and the `a_in`/`b_in` inputs.
- `out_valid` and `out_data` are registered.

## Test plan
- **Basic dot product** (all lanes): len=3, bias=1, a=2/3/4, b=5/6/7 back-to-back -> `out_data`=57, `out_valid` 5 cycles after `start`.
- **Bubbles:** same job with `in_valid` low for 2 cycles between each pair -> still 57; `in_ready` stays high until the 3rd issue.
- **Wrap-around:** len=1, bias=2, a=0x00FF, b=0x0101 -> 0x0001 (0xFFFF+2 mod 2^16); distinct per-lane values checked against a lane model.
- **Backpressure and idle start:**
  - `out_ready` low 5 cycles after `out_valid` -> `out_data` stable, `start` pulses ignored, `in_ready`=0.
  - Accept, then `start` in the next cycle -> new job runs correctly.
- **len=0:** bias=0x1234 -> `out_valid` the next cycle with 0x1234; no MAC issue.
- **Reset mid-RUN:**
  - Assert `rst` after 2 of 4 issues -> all outputs return to reset values.
  - Next job len=1, bias=0, a=3, b=3 -> 9, with no residue from the aborted job.

Source files
------------

// File: rtl/vector_mac_acc_ctrl.sv
// Sequencing/accumulation controller in front of vector_MAC_int: streams LEN operand
// pairs into the MAC, recirculates c_ab as the running sum, and presents the result.
module vector_mac_acc_ctrl #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [LEN_WIDTH-1:0]                len,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]    bias_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]    a_in,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]    b_in,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    mac_a,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    mac_b,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    mac_c,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]    mac_c_ab,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    out_data,
  output logic                                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                           state, state_nxt;
  logic [LEN_WIDTH-1:0]             count, len_q;
  logic [VECTOR-1:0][REG_WIDTH-1:0] bias_q;
  logic                             first;
  logic                             issue;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      len_q    <= '0;
      bias_q   <= '0;
      first    <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q  <= len;
              bias_q <= bias_in;
              count  <= '0;
              first  <= 1'b1;
            end else begin
              out_data <= bias_in;
            end
          end
        end
        RUN: begin
          if (issue) begin
            count <= count + ONE;
            first <= 1'b0;
          end
        end
        DRAIN: out_data <= mac_c_ab;
        DONE: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    issue     = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    mac_c     = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len != '0) ? RUN : DONE;
      end
      RUN: begin
        in_ready = (count < len_q);
        issue    = in_valid & in_ready;
        // Zero operands on bubbles make the MAC simply re-register its own sum.
        mac_c    = first ? bias_q : mac_c_ab;
        if (issue) begin
          mac_a = a_in;
          mac_b = b_in;
          if (count + ONE == len_q) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        mac_c     = mac_c_ab;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
    endcase
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vector_mac_acc_ctrl.sv
// Scoreboard bench for vector_mac_acc_ctrl with a behavioural MAC attached and a
// dot-product reference model computing expected results per lane.
module tb_vector_mac_acc_ctrl;

  localparam int RW  = 16;
  localparam int VEC = 8;
  localparam int LW  = 8;

  typedef logic [VEC-1:0][RW-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [LW-1:0] len = '0;
  vec_t       bias_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  vec_t       a_in = '0;
  vec_t       b_in = '0;
  vec_t       mac_a, mac_b, mac_c;
  vec_t       mac_c_ab;
  logic       out_valid;
  logic       out_ready = 1'b0;
  vec_t       out_data;
  logic       busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  vec_t exp_q[$];
  vec_t qa[$];
  vec_t qb[$];
  vec_t lit_exp = '0;
  bit   lit_chk = 1'b0;

  vector_mac_acc_ctrl #(.REG_WIDTH(RW), .VECTOR(VEC), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_c_ab(mac_c_ab),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Attached MAC: one registered multiply-accumulate per lane, never reset.
  always @(posedge clk)
    for (int l = 0; l < VEC; l++)
      mac_c_ab[l] <= RW'(mac_c[l] + mac_a[l] * mac_b[l]);

  task automatic check(input string name, input logic [VEC*RW-1:0] act, input logic [VEC*RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", out_data, '0);
        failures += (out_data === '0) ? 1 : 0;
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t rand_vec();
    vec_t r;
    for (int l = 0; l < VEC; l++) r[l] = RW'($urandom_range(0, 65535));
    return r;
  endfunction

  // Reference: per lane, bias plus the sum of products, reduced modulo 2^RW.
  function automatic vec_t model(input vec_t bias, input int n);
    vec_t r;
    longint unsigned s;
    for (int l = 0; l < VEC; l++) begin
      s = longint'(bias[l]);
      for (int i = 0; i < n; i++) s += longint'(qa[i][l]) * longint'(qb[i][l]);
      r[l] = s[RW-1:0];
    end
    return r;
  endfunction

  task automatic fill_rand(input int n);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(rand_vec());
      qb.push_back(rand_vec());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_mac_a"}, mac_a, '0);
    check({tag, "_mac_b"}, mac_b, '0);
    check({tag, "_mac_c"}, mac_c, '0);
  endtask

  task automatic run_job(input int n, input vec_t bias, input int bub, input int hold, input bit pulses);
    vec_t e;
    int   s;
    int   t;
    e = model(bias, n);
    exp_q.push_back(e);
    start   = 1'b1;
    len     = LW'(n);
    bias_in = bias;
    s       = cyc_cnt;
    cyc();
    start   = 1'b0;
    len     = LW'($urandom);
    bias_in = rand_vec();
    for (int i = 0; i < n; i++) begin
      repeat (bub) begin
        in_valid = 1'b0;
        check("in_ready_bubble", in_ready, 1'b1);
        cyc();
      end
      in_valid = 1'b1;
      a_in     = qa[i];
      b_in     = qb[i];
      t = 0;
      while (!in_ready && t < 20) begin
        cyc();
        t++;
      end
      if (t == 20) check("in_ready_timeout", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      a_in     = rand_vec();
      b_in     = rand_vec();
    end
    t = 0;
    while (!out_valid && t < 20) begin
      check("in_ready_after_last", in_ready, 1'b0);
      cyc();
      t++;
    end
    check("out_valid", out_valid, 1'b1);
    if (bub == 0) check("latency", cyc_cnt - s, (n == 0) ? 1 : n + 2);
    if (lit_chk) check("literal_result", out_data, lit_exp);
    check("done_mac_a", mac_a, '0);
    check("done_mac_b", mac_b, '0);
    check("done_mac_c", mac_c, '0);
    check("done_busy", busy, 1'b1);
    for (int k = 0; k < hold; k++) begin
      check("hold_data", out_data, e);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      if (pulses) begin
        start = 1'b1;
        len   = LW'($urandom_range(1, 255));
      end
      cyc();
    end
    out_ready = 1'b1;
    start     = pulses;
    cyc();
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_accept", busy, 1'b0);
    check("valid_after_accept", out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc();
    check_reset_outputs("idle");

    // Basic dot product, back-to-back operands.
    qa.delete(); qb.delete();
    qa.push_back({VEC{16'd2}}); qb.push_back({VEC{16'd5}});
    qa.push_back({VEC{16'd3}}); qb.push_back({VEC{16'd6}});
    qa.push_back({VEC{16'd4}}); qb.push_back({VEC{16'd7}});
    lit_exp = {VEC{16'd57}};
    lit_chk = 1'b1;
    run_job(3, {VEC{16'd1}}, 0, 0, 1'b0);
    // Same job with two-cycle bubbles between pairs.
    run_job(3, {VEC{16'd1}}, 2, 0, 1'b0);

    // Wrap-around.
    qa.delete(); qb.delete();
    qa.push_back({VEC{16'h00FF}}); qb.push_back({VEC{16'h0101}});
    lit_exp = {VEC{16'h0001}};
    run_job(1, {VEC{16'd2}}, 0, 0, 1'b0);
    lit_chk = 1'b0;
    fill_rand(1);
    run_job(1, rand_vec(), 0, 0, 1'b0);

    // Backpressure with ignored start pulses, then immediate restart.
    fill_rand(3);
    run_job(3, rand_vec(), 0, 5, 1'b1);
    fill_rand(2);
    run_job(2, rand_vec(), 0, 0, 1'b0);

    // len = 0 returns the bias one cycle after start.
    lit_exp = {VEC{16'h1234}};
    lit_chk = 1'b1;
    run_job(0, {VEC{16'h1234}}, 0, 0, 1'b0);
    lit_chk = 1'b0;

    // Reset after two of four issues.
    fill_rand(4);
    start   = 1'b1;
    len     = LW'(4);
    bias_in = rand_vec();
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_in     = qa[i];
      b_in     = qb[i];
      check("abort_in_ready", in_ready, 1'b1);
      cyc();
    end
    rst = 1'b1;
    cyc();
    check_reset_outputs("mid_run_reset");
    rst      = 1'b0;
    in_valid = 1'b0;
    cyc();
    check("post_reset_busy", busy, 1'b0);
    qa.delete(); qb.delete();
    qa.push_back({VEC{16'd3}}); qb.push_back({VEC{16'd3}});
    lit_exp = {VEC{16'd9}};
    lit_chk = 1'b1;
    run_job(1, '0, 0, 0, 1'b0);
    lit_chk = 1'b0;

    // Random jobs.
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 6);
      fill_rand(n);
      run_job(n, rand_vec(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (2) cyc();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
